bomba_controle: RTL and testbench



---
 rtl/bomba_controle.sv | 105 ++++++++++
 tb/tb_bomba_controle.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/bomba_controle.sv
// bomba_controle: bomb-game master FSM with a BCD seconds countdown and password attempts.
// Optional macro BOMBA_PENALIDADE_EN: wrong attempts also remove PENALIDADE seconds.
module bomba_controle #(
  parameter int          TEMPO_INICIAL = 60,
  parameter logic [3:0]  SENHA         = 4'hA,
  parameter int          MAX_ERROS     = 3,
  parameter int          PENALIDADE    = 5
) (
  input  logic       clk_1Hz,
  input  logic       reset,
  input  logic       armar,
  input  logic       confirmar,
  input  logic [3:0] senha_in,
  output logic [3:0] tempo_dezenas,
  output logic [3:0] tempo_unidades,
  output logic [1:0] erros,
  output logic [1:0] estado,
  output logic       sinalderrota,
  output logic       sinalvitoria
);

  typedef enum logic [1:0] {
    OCIOSO  = 2'b00,
    ARMADA  = 2'b01,
    DERROTA = 2'b10,
    VITORIA = 2'b11
  } estado_t;

  localparam logic [3:0] DEZ_INI = 4'(TEMPO_INICIAL / 10);
  localparam logic [3:0] UNI_INI = 4'(TEMPO_INICIAL % 10);
  localparam logic [1:0] ERROS_LIM = 2'(MAX_ERROS);

`ifdef BOMBA_PENALIDADE_EN
  localparam logic [6:0] DEC_ERRO = 7'(1 + PENALIDADE);
`else
  localparam logic [6:0] DEC_ERRO = 7'd1;
`endif

  estado_t    estado_q;
  logic       confirmar_ant;
  logic       tentativa;
  logic       senha_ok;
  logic [6:0] tempo_bin;
  logic [6:0] tempo_menos1;
  logic [6:0] tempo_erro;
  logic [1:0] erros_novo;

  // Subtraction goes through binary so a multi-second penalty borrows correctly.
  function automatic logic [6:0] sub_sat(input logic [6:0] t, input logic [6:0] d);
    return (t > d) ? (t - d) : 7'd0;
  endfunction

  assign tentativa    = confirmar & ~confirmar_ant;
  assign senha_ok     = (senha_in == SENHA);
  assign tempo_bin    = ({3'b000, tempo_dezenas} * 7'd10) + {3'b000, tempo_unidades};
  assign tempo_menos1 = sub_sat(tempo_bin, 7'd1);
  assign tempo_erro   = sub_sat(tempo_bin, DEC_ERRO);
  assign erros_novo   = erros + 2'd1;
  assign estado       = estado_q;

  always_ff @(posedge clk_1Hz) begin
    if (reset) begin
      estado_q       <= OCIOSO;
      tempo_dezenas  <= DEZ_INI;
      tempo_unidades <= UNI_INI;
      erros          <= 2'd0;
      sinalderrota   <= 1'b0;
      sinalvitoria   <= 1'b0;
      confirmar_ant  <= 1'b0;
    end else begin
      confirmar_ant <= confirmar;
      case (estado_q)
        OCIOSO: begin
          tempo_dezenas  <= DEZ_INI;
          tempo_unidades <= UNI_INI;
          erros          <= 2'd0;
          if (armar) estado_q <= ARMADA;
        end
        ARMADA: begin
          if (tentativa && senha_ok) begin
            estado_q     <= VITORIA;
            sinalvitoria <= 1'b1;
          end else if (tentativa) begin
            erros          <= erros_novo;
            tempo_dezenas  <= 4'(tempo_erro / 7'd10);
            tempo_unidades <= 4'(tempo_erro % 7'd10);
            if (erros_novo == ERROS_LIM || tempo_erro == 7'd0) begin
              estado_q     <= DERROTA;
              sinalderrota <= 1'b1;
            end
          end else begin
            tempo_dezenas  <= 4'(tempo_menos1 / 7'd10);
            tempo_unidades <= 4'(tempo_menos1 % 7'd10);
            if (tempo_menos1 == 7'd0) begin
              estado_q     <= DERROTA;
              sinalderrota <= 1'b1;
            end
          end
        end
        default: ;  // terminal states hold until reset
      endcase
    end
  end

endmodule

// File: tb/tb_bomba_controle.sv
// Directed self-checking bench for bomba_controle (10 s instance plus a 20 s instance for penalty).
module tb_bomba_controle;

  logic       clk_1Hz = 1'b0;
  logic       reset, armar, confirmar, armar2, confirmar2;
  logic [3:0] senha_in, senha2;
  logic [3:0] t_dez, t_uni, t_dez2, t_uni2;
  logic [1:0] erros, estado, erros2, estado2;
  logic       sd, sv, sd2, sv2;

  int n_asserts = 0;
  int n_fail    = 0;
  int exp_t;
  int exp_e;

  localparam logic [1:0] OCIOSO = 2'b00, ARMADA = 2'b01, DERROTA = 2'b10, VITORIA = 2'b11;

`ifdef BOMBA_PENALIDADE_EN
  localparam int DEC_ERRO = 6;
`else
  localparam int DEC_ERRO = 1;
`endif

  bomba_controle #(.TEMPO_INICIAL(10)) dut (
    .clk_1Hz(clk_1Hz), .reset(reset), .armar(armar), .confirmar(confirmar),
    .senha_in(senha_in), .tempo_dezenas(t_dez), .tempo_unidades(t_uni),
    .erros(erros), .estado(estado), .sinalderrota(sd), .sinalvitoria(sv)
  );

  bomba_controle #(.TEMPO_INICIAL(20), .PENALIDADE(5)) dut20 (
    .clk_1Hz(clk_1Hz), .reset(reset), .armar(armar2), .confirmar(confirmar2),
    .senha_in(senha2), .tempo_dezenas(t_dez2), .tempo_unidades(t_uni2),
    .erros(erros2), .estado(estado2), .sinalderrota(sd2), .sinalvitoria(sv2)
  );

  always #5 clk_1Hz = ~clk_1Hz;

  task automatic tick();
    @(posedge clk_1Hz);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    n_asserts++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Full observable state of the 10 s instance; time given in seconds.
  task automatic chk_all(input string tag, input int t, input int e, input logic [1:0] st);
    chk({tag, " dezenas"}, {4'h0, t_dez}, 8'(t / 10));
    chk({tag, " unidades"}, {4'h0, t_uni}, 8'(t % 10));
    chk({tag, " erros"}, {6'h0, erros}, 8'(e));
    chk({tag, " estado"}, {6'h0, estado}, {6'h0, st});
    chk({tag, " sinalderrota"}, {7'h0, sd}, {7'h0, (st == DERROTA)});
    chk({tag, " sinalvitoria"}, {7'h0, sv}, {7'h0, (st == VITORIA)});
  endtask

  task automatic chk_all2(input string tag, input int t, input int e, input logic [1:0] st);
    chk({tag, " dezenas"}, {4'h0, t_dez2}, 8'(t / 10));
    chk({tag, " unidades"}, {4'h0, t_uni2}, 8'(t % 10));
    chk({tag, " erros"}, {6'h0, erros2}, 8'(e));
    chk({tag, " estado"}, {6'h0, estado2}, {6'h0, st});
    chk({tag, " sinalderrota"}, {7'h0, sd2}, {7'h0, (st == DERROTA)});
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; armar = 1'b0; confirmar = 1'b0; senha_in = 4'h0;
    armar2 = 1'b0; confirmar2 = 1'b0; senha2 = 4'h0;

    // Reset state and idle behaviour
    tick();
    reset = 1'b0;
    chk_all("reset", 10, 0, OCIOSO);
    chk_all2("reset20", 20, 0, OCIOSO);
    confirmar = 1'b1; senha_in = 4'h3;
    tick();
    confirmar = 1'b0;
    tick();
    chk_all("idle ignores attempt", 10, 0, OCIOSO);

    // Timeout
    armar = 1'b1;
    tick();
    armar = 1'b0;
    chk_all("armed", 10, 0, ARMADA);
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk_all($sformatf("timeout k=%0d", k), 10 - k, 0, (k == 10) ? DERROTA : ARMADA);
    end
    armar = 1'b1; confirmar = 1'b1; senha_in = 4'hA;
    for (int k = 0; k < 3; k++) tick();
    armar = 1'b0; confirmar = 1'b0;
    chk_all("defeat holds", 0, 0, DERROTA);

    // Correct attempt at 07
    do_reset();
    chk_all("reset from defeat", 10, 0, OCIOSO);
    armar = 1'b1;
    tick();
    armar = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    chk_all("at 07", 7, 0, ARMADA);
    senha_in = 4'hA; confirmar = 1'b1;
    tick();
    confirmar = 1'b0;
    chk_all("victory", 7, 0, VITORIA);
    senha_in = 4'h3;
    for (int k = 0; k < 20; k++) begin
      confirmar = (k % 2 == 0);
      tick();
    end
    confirmar = 1'b0;
    chk_all("victory frozen", 7, 0, VITORIA);

    // Error limit
    do_reset();
    armar = 1'b1;
    tick();
    armar = 1'b0;
    senha_in = 4'h3;
    confirmar = 1'b1; tick(); chk_all("err1", 9, 1, ARMADA);
    confirmar = 1'b0; tick(); chk_all("err1 gap", 8, 1, ARMADA);
    confirmar = 1'b1; tick(); chk_all("err2", 7, 2, ARMADA);
    confirmar = 1'b0; tick(); chk_all("err2 gap", 6, 2, ARMADA);
    confirmar = 1'b1; tick(); chk_all("err3 defeat", 5, 3, DERROTA);
    confirmar = 1'b0; tick(); chk_all("err3 hold", 5, 3, DERROTA);

    // Held button counts once, then reset mid-game at 05 with two errors
    do_reset();
    armar = 1'b1;
    tick();
    armar = 1'b0;
    senha_in = 4'h3; confirmar = 1'b1;
    for (int k = 0; k < 3; k++) tick();
    chk_all("held button", 7, 1, ARMADA);
    confirmar = 1'b0; tick();
    confirmar = 1'b1; tick();
    confirmar = 1'b0;
    chk_all("before mid reset", 5, 2, ARMADA);
    do_reset();
    chk_all("mid-game reset", 10, 0, OCIOSO);
    armar = 1'b1;
    tick();
    armar = 1'b0;
    chk_all("re-armed", 10, 0, ARMADA);
    for (int k = 0; k < 9; k++) tick();
    chk_all("at 01", 1, 0, ARMADA);
    senha_in = 4'hA; confirmar = 1'b1;
    tick();
    confirmar = 1'b0;
    chk_all("win at 01", 1, 0, VITORIA);
    tick();
    chk_all("win at 01 hold", 1, 0, VITORIA);

    // Penalty on the 20 s instance
    do_reset();
    armar2 = 1'b1;
    tick();
    armar2 = 1'b0;
    chk_all2("armed20", 20, 0, ARMADA);
    senha2 = 4'h3; confirmar2 = 1'b1;
    tick();
    confirmar2 = 1'b0;
    exp_t = 20 - DEC_ERRO;
    exp_e = 1;
    chk_all2("penalty at 20", exp_t, exp_e, ARMADA);
    while (exp_t > 4) begin
      tick();
      exp_t--;
    end
    chk_all2("at 04", 4, exp_e, ARMADA);
    confirmar2 = 1'b1;
    tick();
    confirmar2 = 1'b0;
    exp_t = (4 > DEC_ERRO) ? 4 - DEC_ERRO : 0;
    exp_e = 2;
    chk_all2("penalty at 04", exp_t, exp_e, (exp_t == 0) ? DERROTA : ARMADA);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
